// File: rtl/vm_change_dispenser.sv
// Change dispenser: greedy largest-coin-first payout through a hopper req/ack
// handshake, with per-denomination inventory, shortfall reporting and jam detection.
module vm_change_dispenser #(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned VAL_Q       = 25,
    parameter int unsigned VAL_D       = 10,
    parameter int unsigned VAL_N       = 5,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    output logic             chg_ready,
    input  logic [AMT_W-1:0] chg_amount,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] short_amount,
    output logic             busy,
    output logic             jam,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_q,
    input  logic [CNT_W-1:0] load_d,
    input  logic [CNT_W-1:0] load_n,
    output logic [CNT_W-1:0] inv_q,
    output logic [CNT_W-1:0] inv_d,
    output logic [CNT_W-1:0] inv_n
);

    localparam int unsigned TO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_DISPENSE = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_JAM      = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic [CNT_W-1:0] inv_q_nxt, inv_d_nxt, inv_n_nxt;
    logic             coin_req_nxt, done_nxt, short_nxt, busy_nxt, jam_nxt;
    logic [1:0]       coin_sel_nxt;
    logic [AMT_W-1:0] short_amount_nxt;
    logic [AMT_W-1:0] sel_val;
    logic             q_ok, d_ok, n_ok;

    // Ready is a live decode so a load in the same cycle blocks acceptance.
    assign chg_ready = (state == S_IDLE) && !load_en;

    assign q_ok = (rem >= AMT_W'(VAL_Q)) && (inv_q != '0);
    assign d_ok = (rem >= AMT_W'(VAL_D)) && (inv_d != '0);
    assign n_ok = (rem >= AMT_W'(VAL_N)) && (inv_n != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rem          <= '0;
            to_cnt       <= '0;
            inv_q        <= '0;
            inv_d        <= '0;
            inv_n        <= '0;
            coin_req     <= 1'b0;
            coin_sel     <= 2'd0;
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            busy         <= 1'b0;
            jam          <= 1'b0;
        end else begin
            state        <= state_nxt;
            rem          <= rem_nxt;
            to_cnt       <= to_cnt_nxt;
            inv_q        <= inv_q_nxt;
            inv_d        <= inv_d_nxt;
            inv_n        <= inv_n_nxt;
            coin_req     <= coin_req_nxt;
            coin_sel     <= coin_sel_nxt;
            done         <= done_nxt;
            short        <= short_nxt;
            short_amount <= short_amount_nxt;
            busy         <= busy_nxt;
            jam          <= jam_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        rem_nxt          = rem;
        to_cnt_nxt       = to_cnt;
        inv_q_nxt        = inv_q;
        inv_d_nxt        = inv_d;
        inv_n_nxt        = inv_n;
        coin_req_nxt     = coin_req;
        coin_sel_nxt     = coin_sel;
        done_nxt         = 1'b0;
        short_nxt        = short;
        short_amount_nxt = short_amount;
        busy_nxt         = busy;
        jam_nxt          = jam;

        case (coin_sel)
            2'd0:    sel_val = AMT_W'(VAL_Q);
            2'd1:    sel_val = AMT_W'(VAL_D);
            2'd2:    sel_val = AMT_W'(VAL_N);
            default: sel_val = '0;
        endcase

        case (state)
            S_IDLE: begin
                if (load_en) begin
                    inv_q_nxt = load_q;
                    inv_d_nxt = load_d;
                    inv_n_nxt = load_n;
                end else if (chg_valid) begin
                    rem_nxt          = chg_amount;
                    short_nxt        = 1'b0;
                    short_amount_nxt = '0;
                    busy_nxt         = 1'b1;
                    state_nxt        = S_SELECT;
                end
            end
            S_SELECT: begin
                to_cnt_nxt = '0;
                if (rem == '0) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_DONE;
                end else if (q_ok || d_ok || n_ok) begin
                    coin_sel_nxt = q_ok ? 2'd0 : (d_ok ? 2'd1 : 2'd2);
                    coin_req_nxt = 1'b1;
                    state_nxt    = S_DISPENSE;
                end else begin
                    short_nxt        = 1'b1;
                    short_amount_nxt = rem;
                    done_nxt         = 1'b1;
                    busy_nxt         = 1'b0;
                    state_nxt        = S_DONE;
                end
            end
            S_DISPENSE: begin
                if (coin_ack) begin
                    case (coin_sel)
                        2'd0:    inv_q_nxt = inv_q - CNT_W'(1);
                        2'd1:    inv_d_nxt = inv_d - CNT_W'(1);
                        2'd2:    inv_n_nxt = inv_n - CNT_W'(1);
                        default: ;
                    endcase
                    rem_nxt      = rem - sel_val;
                    coin_req_nxt = 1'b0;
                    state_nxt    = S_SELECT;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    // Hopper gave no ack for ACK_TIMEOUT cycles: coin is not counted as paid.
                    coin_req_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                    jam_nxt      = 1'b1;
                    state_nxt    = S_JAM;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            S_DONE: state_nxt = S_IDLE;
            S_JAM:  state_nxt = S_JAM;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
